// File: rtl/mem_access_ctrl.sv
// Shared memory-port sequencer for the multicycle MIPS datapath: arbitrates fetch,
// load/store and exception-vector requests, drives IorD/mem_wr and times the memory latency.
module mem_access_ctrl #(
   parameter int MEM_LAT    = 2,
   parameter int CW         = 4,
   parameter int STARVE_MAX = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       if_req,
   output logic       if_ack,
   input  logic       ls_req,
   input  logic       ls_we,
   output logic       ls_ack,
   input  logic       ex_req,
   output logic       ex_ack,
   output logic [2:0] IorD,
   output logic       mem_wr,
   output logic       mem_ld,
   output logic       busy
);
   localparam int LAT = (MEM_LAT < 1) ? 1 : MEM_LAT;
   localparam int SW  = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] LAT_M1     = CW'(LAT - 1);
   localparam logic [CW-1:0] CNT_ONE    = CW'(1);
   localparam logic [SW-1:0] STARVE_SAT = SW'(STARVE_MAX);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ADDR = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [1:0] OWN_IF = 2'd0;
   localparam logic [1:0] OWN_LS = 2'd1;
   localparam logic [1:0] OWN_EX = 2'd2;

   logic [1:0]    r_state;
   logic [1:0]    w_state_nxt;
   logic [1:0]    r_owner;
   logic [1:0]    w_owner_nxt;
   logic          r_wr_q;
   logic          w_wr_nxt;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_nxt;
   logic [SW-1:0] r_starve;
   logic [SW-1:0] w_starve_nxt;
   logic [1:0]    w_win;
   logic          w_any_req;
   logic          w_starved;
   logic          w_is_store;

   assign w_any_req  = if_req | ls_req | ex_req;
   assign w_starved  = (r_starve == STARVE_SAT);
   assign w_is_store = (r_owner == OWN_LS) && r_wr_q;

   // A starved fetch jumps ahead of load/store but never ahead of an exception vector.
   always_comb begin
      w_win = OWN_IF;
      if (ex_req)
         w_win = OWN_EX;
      else if (if_req && w_starved)
         w_win = OWN_IF;
      else if (ls_req)
         w_win = OWN_LS;
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_owner_nxt  = r_owner;
      w_wr_nxt     = r_wr_q;
      w_cnt_nxt    = r_cnt;
      w_starve_nxt = r_starve;
      case (r_state)
         S_IDLE: begin
            if (!if_req || (w_win == OWN_IF))
               w_starve_nxt = '0;
            else if (!w_starved)
               w_starve_nxt = r_starve + 1'b1;
            if (w_any_req) begin
               w_state_nxt = S_ADDR;
               w_owner_nxt = w_win;
               w_wr_nxt    = ls_we;
            end
         end
         S_ADDR: begin
            w_cnt_nxt   = LAT_M1;
            w_state_nxt = (LAT <= 1) ? S_DONE : S_WAIT;
         end
         S_WAIT: begin
            w_cnt_nxt = r_cnt - 1'b1;
            if (r_cnt <= CNT_ONE)
               w_state_nxt = S_DONE;
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= S_IDLE;
         r_owner  <= OWN_IF;
         r_wr_q   <= 1'b0;
         r_cnt    <= '0;
         r_starve <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_owner  <= w_owner_nxt;
         r_wr_q   <= w_wr_nxt;
         r_cnt    <= w_cnt_nxt;
         r_starve <= w_starve_nxt;
      end
   end

   // Outputs decode registered state only, so an async reset clears them immediately.
   always_comb begin
      IorD   = 3'b000;
      mem_wr = 1'b0;
      mem_ld = 1'b0;
      busy   = 1'b0;
      if_ack = 1'b0;
      ls_ack = 1'b0;
      ex_ack = 1'b0;
      if (r_state != S_IDLE) begin
         busy = 1'b1;
         case (r_owner)
            OWN_LS:  IorD = 3'b010;
            OWN_EX:  IorD = 3'b011;
            default: IorD = 3'b000;
         endcase
      end
      if (r_state == S_ADDR)
         mem_wr = w_is_store;
      if (r_state == S_DONE) begin
         mem_ld = !w_is_store;
         if_ack = (r_owner == OWN_IF);
         ls_ack = (r_owner == OWN_LS);
         ex_ack = (r_owner == OWN_EX);
      end
   end

endmodule
